// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: lane modes, fixed code words, disparity width and
// the combinational helpers used by every lane encoder.
package tmds_pkg;

  typedef enum logic [1:0] {
    MODE_CTRL  = 2'b00,
    MODE_VIDEO = 2'b01,
    MODE_GUARD = 2'b10,
    MODE_TERC4 = 2'b11
  } tmds_mode_e;

  localparam int CNT_W = 5;

  localparam logic [9:0] CTRL_00 = 10'h354;
  localparam logic [9:0] CTRL_01 = 10'h0AB;
  localparam logic [9:0] CTRL_10 = 10'h154;
  localparam logic [9:0] CTRL_11 = 10'h2AB;

  localparam logic [9:0] GUARD_LANE1 = 10'h133;
  localparam logic [9:0] GUARD_OTHER = 10'h2CC;

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    case (c)
      2'b00:   return CTRL_00;
      2'b01:   return CTRL_01;
      2'b10:   return CTRL_10;
      default: return CTRL_11;
    endcase
  endfunction

  function automatic logic [9:0] terc4_code(input logic [3:0] a);
    case (a)
      4'h0:    return 10'h29C;
      4'h1:    return 10'h263;
      4'h2:    return 10'h2E4;
      4'h3:    return 10'h2E2;
      4'h4:    return 10'h171;
      4'h5:    return 10'h11E;
      4'h6:    return 10'h18E;
      4'h7:    return 10'h13C;
      4'h8:    return 10'h2CC;
      4'h9:    return 10'h139;
      4'hA:    return 10'h19C;
      4'hB:    return 10'h2C6;
      4'hC:    return 10'h28E;
      4'hD:    return 10'h271;
      4'hE:    return 10'h163;
      default: return 10'h2C3;
    endcase
  endfunction

  function automatic logic [3:0] ones8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
    return n;
  endfunction

  // Transition-minimising first stage; q_m[8] records XOR (1) vs XNOR (0).
  function automatic logic [8:0] stage1_qm(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] qm;
    n1       = ones8(d);
    use_xnor = (n1 > 4'd4) || (n1 == 4'd4 && !d[0]);
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++)
      qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8]    = ~use_xnor;
    return qm;
  endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// One TMDS lane: stage 1 registers the transition-minimised word and mode,
// stage 2 applies DC balance / fixed codes and owns the disparity counter.
module tmds_channel_enc
  import tmds_pkg::*;
#(
  parameter bit HDMI_EN  = 1'b0,
  parameter bit IS_LANE1 = 1'b0
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic       clk_en,
  input  logic [1:0] mode,
  input  logic [7:0] data,
  input  logic [1:0] ctrl,
  input  logic [3:0] aux,
  output logic [9:0] sym
);

  localparam logic signed [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic signed [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  tmds_mode_e              r_mode;
  logic [8:0]              r_qm;
  logic [1:0]              r_ctrl;
  logic [3:0]              r_aux;
  logic [9:0]              r_sym;
  logic signed [CNT_W-1:0] r_cnt;

  tmds_mode_e              w_mode_in;
  logic [3:0]              w_n1;
  logic [3:0]              w_n0;
  logic signed [CNT_W-1:0] w_diff;
  logic [9:0]              w_sym_next;
  logic signed [CNT_W-1:0] w_cnt_next;

  // Without HDMI support the island modes collapse to control at the input.
  assign w_mode_in = (!HDMI_EN && mode[1]) ? MODE_CTRL : tmds_mode_e'(mode);

  // NOTE: async reset plus non-blocking assignments keep every flop updating
  // from pre-edge values, so the two stages never race each other.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_mode <= MODE_CTRL;
      r_qm   <= '0;
      r_ctrl <= '0;
      r_aux  <= '0;
    end else if (clk_en) begin
      r_mode <= w_mode_in;
      r_qm   <= stage1_qm(data);
      r_ctrl <= ctrl;
      r_aux  <= aux;
    end
  end

  assign w_n1   = ones8(r_qm[7:0]);
  assign w_n0   = 4'd8 - w_n1;
  assign w_diff = $signed({1'b0, w_n1}) - $signed({1'b0, w_n0});

  // NOTE: both outputs get a default first so no path through the case can
  // leave them unassigned and infer a latch.
  always_comb begin
    w_sym_next = ctrl_code(r_ctrl);
    w_cnt_next = CNT_ZERO;
    case (r_mode)
      MODE_VIDEO: begin
        if (r_cnt == CNT_ZERO || w_n1 == w_n0) begin
          w_sym_next = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
          w_cnt_next = r_qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
        end else if ((r_cnt > CNT_ZERO && w_n1 > w_n0) ||
                     (r_cnt < CNT_ZERO && w_n0 > w_n1)) begin
          w_sym_next = {1'b1, r_qm[8], ~r_qm[7:0]};
          w_cnt_next = r_cnt + (r_qm[8] ? CNT_TWO : CNT_ZERO) - w_diff;
        end else begin
          w_sym_next = {1'b0, r_qm[8], r_qm[7:0]};
          w_cnt_next = r_cnt - (r_qm[8] ? CNT_ZERO : CNT_TWO) + w_diff;
        end
      end
      MODE_GUARD: w_sym_next = IS_LANE1 ? GUARD_LANE1 : GUARD_OTHER;
      MODE_TERC4: w_sym_next = terc4_code(r_aux);
      default:    w_sym_next = ctrl_code(r_ctrl);
    endcase
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_sym <= CTRL_00;
      r_cnt <= CNT_ZERO;
    end else if (clk_en) begin
      r_sym <= w_sym_next;
      r_cnt <= w_cnt_next;
    end
  end

  assign sym = r_sym;

endmodule

// File: rtl/tmds_encoder_bank.sv
// Bank of CHANNELS parallel TMDS lane encoders sharing one mode input, with a
// two-deep valid pipeline matching the encoder latency.
module tmds_encoder_bank
  import tmds_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter bit HDMI_EN  = 1'b0
) (
  input  logic                     clk_pixel,
  input  logic                     reset_n,
  input  logic                     clk_en,
  input  logic [1:0]               mode,
  input  logic [CHANNELS*8-1:0]    data,
  input  logic [CHANNELS*2-1:0]    ctrl,
  input  logic [CHANNELS*4-1:0]    aux,
  output logic [CHANNELS*10-1:0]   sym,
  output logic                     sym_valid
);

  logic [1:0] r_vld;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= '0;
    end else if (clk_en) begin
      r_vld <= {r_vld[0], 1'b1};
    end
  end

  assign sym_valid = r_vld[1];

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    tmds_channel_enc #(
      .HDMI_EN  (HDMI_EN),
      .IS_LANE1 (k == 1)
    ) u_enc (
      .clk_pixel (clk_pixel),
      .reset_n   (reset_n),
      .clk_en    (clk_en),
      .mode      (mode),
      .data      (data[8*k +: 8]),
      .ctrl      (ctrl[2*k +: 2]),
      .aux       (aux[4*k +: 4]),
      .sym       (sym[10*k +: 10])
    );
  end

endmodule

// File: tb/tb_tmds_encoder_bank.sv
// Directed bench for tmds_encoder_bank: one DVI-only and one HDMI-enabled
// instance driven from the same stimulus, checked against hand-computed codes.
module tb_tmds_encoder_bank;

  localparam int CH = 3;

  logic               clk_pixel = 1'b0;
  logic               reset_n   = 1'b0;
  logic               clk_en    = 1'b0;
  logic [1:0]         mode      = 2'b00;
  logic [CH*8-1:0]    data      = '0;
  logic [CH*2-1:0]    ctrl      = '0;
  logic [CH*4-1:0]    aux       = '0;
  logic [CH*10-1:0]   sym;
  logic [CH*10-1:0]   sym_h;
  logic               sym_valid;
  logic               sym_valid_h;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk_pixel = ~clk_pixel;

  tmds_encoder_bank #(.CHANNELS(CH), .HDMI_EN(1'b0)) dut (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .clk_en    (clk_en),
    .mode      (mode),
    .data      (data),
    .ctrl      (ctrl),
    .aux       (aux),
    .sym       (sym),
    .sym_valid (sym_valid)
  );

  tmds_encoder_bank #(.CHANNELS(CH), .HDMI_EN(1'b1)) dut_h (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .clk_en    (clk_en),
    .mode      (mode),
    .data      (data),
    .ctrl      (ctrl),
    .aux       (aux),
    .sym       (sym_h),
    .sym_valid (sym_valid_h)
  );

  function automatic logic [9:0] lane(input logic [CH*10-1:0] s, input int k);
    return s[10*k +: 10];
  endfunction

  task automatic step();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic flush_ctrl();
    mode = 2'b00; ctrl = '0; data = '0; aux = '0;
    step();
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clk_en = 1'b1;
    repeat (3) step();
    for (int k = 0; k < CH; k++) begin
      n_vec++;
      if (lane(sym, k) !== 10'h354) begin
        $display("FAIL reset_sym lane%0d got %h want 354", k, lane(sym, k)); n_miss++;
      end
      n_vec++;
      if (lane(sym_h, k) !== 10'h354) begin
        $display("FAIL reset_sym_h lane%0d got %h want 354", k, lane(sym_h, k)); n_miss++;
      end
    end
    n_vec++;
    if (sym_valid !== 1'b0 || sym_valid_h !== 1'b0) begin
      $display("FAIL reset_valid got %b/%b want 0/0", sym_valid, sym_valid_h); n_miss++;
    end
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_vec++;
      if (sym_valid !== (c >= 1)) begin
        $display("FAIL release_valid cycle%0d got %b want %b", c, sym_valid, (c >= 1)); n_miss++;
      end
      for (int k = 0; k < CH; k++) begin
        n_vec++;
        if (lane(sym, k) !== 10'h354) begin
          $display("FAIL release_sym cycle%0d lane%0d got %h want 354", c, k, lane(sym, k)); n_miss++;
        end
      end
    end
  endtask

  task automatic test_video();
    logic [9:0] exp0 [4];
    logic [9:0] exp1 [4];
    logic [9:0] exp2 [4];
    exp0 = '{10'h200, 10'h0FF, 10'h0FF, 10'h200};
    exp1 = '{10'h100, 10'h3FF, 10'h100, 10'h3FF};
    exp2 = '{10'h1FF, 10'h300, 10'h300, 10'h1FF};
    mode = 2'b01; data = {8'h01, 8'h00, 8'hFF};
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      n_vec++;
      if (lane(sym, 0) !== exp0[i]) begin
        $display("FAIL video_l0 sym%0d got %h want %h", i, lane(sym, 0), exp0[i]); n_miss++;
      end
      n_vec++;
      if (lane(sym, 1) !== exp1[i]) begin
        $display("FAIL video_l1 sym%0d got %h want %h", i, lane(sym, 1), exp1[i]); n_miss++;
      end
      n_vec++;
      if (lane(sym_h, 2) !== exp2[i]) begin
        $display("FAIL video_l2 sym%0d got %h want %h", i, lane(sym_h, 2), exp2[i]); n_miss++;
      end
    end
    flush_ctrl();
  endtask

  task automatic test_control();
    logic [1:0] in0 [4];
    logic [9:0] exp0 [3];
    in0  = '{2'b01, 2'b10, 2'b11, 2'b00};
    exp0 = '{10'h0AB, 10'h154, 10'h2AB};
    mode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      ctrl = {2'b11, 2'b10, in0[i]};
      step();
      if (i >= 1) begin
        n_vec++;
        if (lane(sym, 0) !== exp0[i-1]) begin
          $display("FAIL ctrl_l0 step%0d got %h want %h", i, lane(sym, 0), exp0[i-1]); n_miss++;
        end
        n_vec++;
        if (lane(sym, 1) !== 10'h154 || lane(sym, 2) !== 10'h2AB) begin
          $display("FAIL ctrl_l12 step%0d got %h/%h want 154/2ab", i, lane(sym, 1), lane(sym, 2)); n_miss++;
        end
      end
    end
    flush_ctrl();
  endtask

  task automatic test_clk_en_hold();
    mode = 2'b01; data = {8'h00, 8'h00, 8'hFF};
    step();
    step();
    n_vec++;
    if (lane(sym, 0) !== 10'h200) begin
      $display("FAIL hold_pre got %h want 200", lane(sym, 0)); n_miss++;
    end
    clk_en = 1'b0; mode = 2'b00; data = {8'h12, 8'h34, 8'h56};
    for (int c = 0; c < 5; c++) begin
      step();
      n_vec++;
      if (lane(sym, 0) !== 10'h200 || sym_valid !== 1'b1) begin
        $display("FAIL hold_frozen cycle%0d got %h/%b want 200/1", c, lane(sym, 0), sym_valid); n_miss++;
      end
    end
    mode = 2'b01; data = {8'h00, 8'h00, 8'hFF}; clk_en = 1'b1;
    step();
    n_vec++;
    if (lane(sym, 0) !== 10'h0FF) begin
      $display("FAIL hold_resume got %h want 0ff", lane(sym, 0)); n_miss++;
    end
    flush_ctrl();
  endtask

  task automatic test_guard_terc4();
    logic [9:0] exp_g [CH];
    logic [9:0] exp_a [CH];
    logic [9:0] exp_b [CH];
    exp_g = '{10'h2CC, 10'h133, 10'h2CC};
    exp_a = '{10'h29C, 10'h263, 10'h2CC};
    exp_b = '{10'h2C3, 10'h13C, 10'h19C};
    mode = 2'b10; ctrl = '0; data = '0;
    step();
    step();
    for (int k = 0; k < CH; k++) begin
      n_vec++;
      if (lane(sym_h, k) !== exp_g[k]) begin
        $display("FAIL guard_h lane%0d got %h want %h", k, lane(sym_h, k), exp_g[k]); n_miss++;
      end
      n_vec++;
      if (lane(sym, k) !== 10'h354) begin
        $display("FAIL guard_dvi lane%0d got %h want 354", k, lane(sym, k)); n_miss++;
      end
    end
    mode = 2'b11; aux = {4'b1000, 4'b0001, 4'b0000};
    step();
    aux = {4'b1010, 4'b0111, 4'b1111};
    step();
    for (int k = 0; k < CH; k++) begin
      n_vec++;
      if (lane(sym_h, k) !== exp_a[k]) begin
        $display("FAIL terc4_a lane%0d got %h want %h", k, lane(sym_h, k), exp_a[k]); n_miss++;
      end
    end
    step();
    for (int k = 0; k < CH; k++) begin
      n_vec++;
      if (lane(sym_h, k) !== exp_b[k]) begin
        $display("FAIL terc4_b lane%0d got %h want %h", k, lane(sym_h, k), exp_b[k]); n_miss++;
      end
      n_vec++;
      if (lane(sym, k) !== 10'h354) begin
        $display("FAIL terc4_dvi lane%0d got %h want 354", k, lane(sym, k)); n_miss++;
      end
    end
    flush_ctrl();
  endtask

  task automatic test_cnt_clear_and_async_reset();
    logic [1:0] in_mode [6];
    logic [9:0] exp0 [5];
    in_mode = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01};
    exp0    = '{10'h200, 10'h0FF, 10'h354, 10'h200, 10'h0FF};
    data = {8'h00, 8'h00, 8'hFF}; ctrl = '0;
    for (int i = 0; i < 6; i++) begin
      mode = in_mode[i];
      step();
      if (i >= 1) begin
        n_vec++;
        if (lane(sym, 0) !== exp0[i-1]) begin
          $display("FAIL cnt_clear step%0d got %h want %h", i, lane(sym, 0), exp0[i-1]); n_miss++;
        end
      end
    end
    #2 reset_n = 1'b0;
    #1;
    for (int k = 0; k < CH; k++) begin
      n_vec++;
      if (lane(sym, k) !== 10'h354 || lane(sym_h, k) !== 10'h354) begin
        $display("FAIL async_reset lane%0d got %h/%h want 354", k, lane(sym, k), lane(sym_h, k)); n_miss++;
      end
    end
    n_vec++;
    if (sym_valid !== 1'b0 || sym_valid_h !== 1'b0) begin
      $display("FAIL async_reset_valid got %b/%b want 0/0", sym_valid, sym_valid_h); n_miss++;
    end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_video();
    test_control();
    test_clk_en_hold();
    test_guard_terc4();
    test_cnt_clear_and_async_reset();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
